// File: rtl/ysyx_22040895_wb_stage.sv
// Writeback stage in front of the 64-bit, 32-entry integer register file.
// It merges the single-cycle ALU path, which is buffered in a small FIFO,
// with the long-latency LSU/MDU path onto the single regfile write port.
// It also keeps a pending-write scoreboard for the decoder's RAW hazard checks.
//
// Handshakes use strict valid/ready semantics. A transfer happens only in a
// cycle where valid and ready are both high. Ready never depends on valid
// in the same cycle, and ready is held low while rst is high.
//
// Optional feature: define YSYX_22040895_WB_BYPASS_EN to enable forwarding
// from the output register. In that build a match on the output register
// drives fwdX_* and does not count as busy.
module ysyx_22040895_wb_stage #(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int XLEN           = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic            iss_valid_i,
    input  logic            iss_long_i,
    input  logic [4:0]      iss_rd_i,
    input  logic [4:0]      chk_rs1_i,
    input  logic [4:0]      chk_rs2_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            fwd1_valid_o,
    output logic [XLEN-1:0] fwd1_data_o,
    output logic            fwd2_valid_o,
    output logic [XLEN-1:0] fwd2_data_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_waddr_o,
    output logic [XLEN-1:0] wb_wdata_o
);

    localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ALU result FIFO storage. Each slot has a valid bit so the hazard
    // query can scan the slots without doing pointer arithmetic.
    logic [4:0]                fifo_rd   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0]           fifo_data [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;

    logic        fifo_full;
    logic        fifo_nonempty;
    logic        grant_alu;
    logic        grant_lsu;
    logic        push;
    logic        pop;
    logic        lsu_accept;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        fifo_hit1;
    logic        fifo_hit2;
    logic        out_hit1;
    logic        out_hit2;

    // Full and ready come from the registered count only. A pop in the same
    // cycle does not re-open the FIFO.
    always_comb begin
        fifo_full     = (count == CNT_W'(ALU_FIFO_DEPTH));
        fifo_nonempty = (count != '0);
        alu_ready_o   = !rst && !fifo_full;
        lsu_ready_o   = !rst && !fifo_full;
        // The LSU wins the write port unless the FIFO is full. When the FIFO
        // is full it drains first, so ALU results cannot starve.
        grant_alu     = fifo_nonempty && (!lsu_valid_i || fifo_full);
        grant_lsu     = lsu_valid_i && !grant_alu;
        push          = alu_valid_i && alu_ready_o;
        pop           = grant_alu;
        lsu_accept    = lsu_valid_i && lsu_ready_o;
    end

    // FIFO pointers, occupancy and slot valid bits. Reset discards all buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (pop) begin
                head             <= head + PTR_W'(1);
                slot_valid[head] <= 1'b0;
            end
            if (push) begin
                tail             <= tail + PTR_W'(1);
                slot_valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload. It needs no reset because slot_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= alu_rd_i;
            fifo_data[tail] <= alu_data_i;
        end
    end

    // Next scoreboard value. When the same rd is set and cleared in one cycle, the set wins.
    always_comb begin
        pending_next = pending;
        if (lsu_accept) begin
            pending_next[lsu_rd_i] = 1'b0;
        end
        if (iss_valid_i && iss_long_i && (iss_rd_i != 5'd0)) begin
            pending_next[iss_rd_i] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register holding one pending bit per architectural register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Output register that drives the regfile write port. Results with rd=0 are consumed but never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else if (grant_lsu) begin
            wb_we_o    <= (lsu_rd_i != 5'd0);
            wb_waddr_o <= lsu_rd_i;
            wb_wdata_o <= lsu_data_i;
        end else if (grant_alu) begin
            wb_we_o    <= (fifo_rd[head] != 5'd0);
            wb_waddr_o <= fifo_rd[head];
            wb_wdata_o <= fifo_data[head];
        end else begin
            wb_we_o    <= 1'b0;
        end
    end

    // Hazard query. Check the FIFO slots and the output register against rs1 and rs2.
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
            if (slot_valid[i] && (fifo_rd[i] == chk_rs1_i)) fifo_hit1 = 1'b1;
            if (slot_valid[i] && (fifo_rd[i] == chk_rs2_i)) fifo_hit2 = 1'b1;
        end
        out_hit1 = wb_we_o && (wb_waddr_o == chk_rs1_i);
        out_hit2 = wb_we_o && (wb_waddr_o == chk_rs2_i);
`ifdef YSYX_22040895_WB_BYPASS_EN
        rs1_busy_o   = (chk_rs1_i != 5'd0) && (pending[chk_rs1_i] || fifo_hit1);
        rs2_busy_o   = (chk_rs2_i != 5'd0) && (pending[chk_rs2_i] || fifo_hit2);
        fwd1_valid_o = out_hit1 && (chk_rs1_i != 5'd0);
        fwd2_valid_o = out_hit2 && (chk_rs2_i != 5'd0);
        fwd1_data_o  = wb_wdata_o;
        fwd2_data_o  = wb_wdata_o;
`else
        rs1_busy_o   = (chk_rs1_i != 5'd0) && (pending[chk_rs1_i] || fifo_hit1 || out_hit1);
        rs2_busy_o   = (chk_rs2_i != 5'd0) && (pending[chk_rs2_i] || fifo_hit2 || out_hit2);
        fwd1_valid_o = 1'b0;
        fwd2_valid_o = 1'b0;
        fwd1_data_o  = '0;
        fwd2_data_o  = '0;
`endif
    end

endmodule

// File: tb/tb_ysyx_22040895_wb_stage.sv
// Self-checking bench for ysyx_22040895_wb_stage. It runs directed scenarios
// followed by randomized cycles. A behavioural model (a result queue, a
// pending-bit vector and an output-register image) predicts every output.
module tb_ysyx_22040895_wb_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
`ifdef YSYX_22040895_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            iss_valid;
    logic            iss_long;
    logic [4:0]      iss_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            fwd1_valid;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_valid;
    logic [XLEN-1:0] fwd2_data;
    logic            wb_we;
    logic [4:0]      wb_waddr;
    logic [XLEN-1:0] wb_wdata;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [XLEN+4:0] exp_q[$];     // {rd, data} of buffered ALU results, oldest first
    logic [31:0]     m_pend;
    logic            m_we;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_wdata;

    ysyx_22040895_wb_stage #(.ALU_FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
        .iss_valid_i(iss_valid), .iss_long_i(iss_long), .iss_rd_i(iss_rd),
        .chk_rs1_i(chk_rs1), .chk_rs2_i(chk_rs2),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .fwd1_valid_o(fwd1_valid), .fwd1_data_o(fwd1_data),
        .fwd2_valid_o(fwd2_valid), .fwd2_data_o(fwd2_data),
        .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (m_pend[rs]) return 1'b1;
        foreach (exp_q[i]) if (exp_q[i][XLEN+4 -: 5] == rs) return 1'b1;
        if (!BYP && m_we && (m_addr == rs)) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every DUT output against the model prediction for this cycle
    task automatic model_check();
        logic full;
        full = (exp_q.size() == DEPTH);
        chk("alu_ready", alu_ready, !rst && !full);
        chk("lsu_ready", lsu_ready, !rst && !full);
        chk("rs1_busy", rs1_busy, m_busy(chk_rs1));
        chk("rs2_busy", rs2_busy, m_busy(chk_rs2));
        chk("fwd1_valid", fwd1_valid, BYP && m_we && m_addr == chk_rs1 && chk_rs1 != 0);
        chk("fwd2_valid", fwd2_valid, BYP && m_we && m_addr == chk_rs2 && chk_rs2 != 0);
        chk("fwd1_data", fwd1_data, BYP ? m_wdata : '0);
        chk("fwd2_data", fwd2_data, BYP ? m_wdata : '0);
        chk("wb_we", wb_we, m_we);
        chk("wb_waddr", wb_waddr, m_addr);
        chk("wb_wdata", wb_wdata, m_wdata);
    endtask

    // Advance the model over one clock edge using the inputs held this cycle
    task automatic model_update();
        logic            full;
        logic            ga;
        logic            gl;
        logic [XLEN+4:0] e;
        if (rst) begin
            exp_q.delete();
            m_pend  = '0;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
        end else begin
            full = (exp_q.size() == DEPTH);
            ga   = (exp_q.size() != 0) && (!lsu_valid || full);
            gl   = lsu_valid && !ga;
            if (gl) begin
                m_we = (lsu_rd != 0); m_addr = lsu_rd; m_wdata = lsu_data;
            end else if (ga) begin
                e = exp_q.pop_front();
                m_addr = e[XLEN+4 -: 5]; m_wdata = e[XLEN-1:0]; m_we = (m_addr != 0);
            end else begin
                m_we = 1'b0;
            end
            if (alu_valid && !full) exp_q.push_back({alu_rd, alu_data});
            if (lsu_valid && !full) m_pend[lsu_rd] = 1'b0;
            if (iss_valid && iss_long && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            m_pend[0] = 1'b0;
        end
    endtask

    // Driver tasks: inputs are driven on the falling edge and sampled 1 ns later
    task automatic begin_cycle();
        @(negedge clk);
        rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_long = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_long = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        exp_q.delete(); m_pend = '0; m_we = 0; m_addr = 0; m_wdata = 0;
        repeat (2) @(posedge clk);

        // Reset state
        begin_cycle(); rst = 1; settle();
        chk("rst_alu_ready", alu_ready, 0); chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_we", wb_we, 0); chk("rst_waddr", wb_waddr, 0); chk("rst_wdata", wb_wdata, 0);
        end_cycle();

        // ALU only: push in cycle 1, write visible in cycle 3
        begin_cycle(); alu_valid = 1; alu_rd = 5; alu_data = 64'h1234; chk_rs1 = 5; settle();
        chk("alu_c1_ready", alu_ready, 1); chk("alu_c1_busy", rs1_busy, 0);
        end_cycle();
        begin_cycle(); chk_rs1 = 5; settle();
        chk("alu_c2_busy", rs1_busy, 1); chk("alu_c2_we", wb_we, 0);
        end_cycle();
        begin_cycle(); chk_rs1 = 5; settle();
        chk("alu_c3_we", wb_we, 1); chk("alu_c3_addr", wb_waddr, 5); chk("alu_c3_data", wb_wdata, 64'h1234);
        chk("alu_c3_busy", rs1_busy, BYP ? 0 : 1); chk("alu_c3_fwd", fwd1_valid, BYP);
        end_cycle();
        begin_cycle(); chk_rs1 = 5; settle(); chk("alu_c4_busy", rs1_busy, 0); end_cycle();

        // LSU priority over a buffered ALU result
        begin_cycle(); alu_valid = 1; alu_rd = 3; alu_data = 64'h33; settle(); end_cycle();
        begin_cycle(); lsu_valid = 1; lsu_rd = 7; lsu_data = 64'hdead; settle();
        chk("pri_lsu_ready", lsu_ready, 1); end_cycle();
        begin_cycle(); settle(); chk("pri_first", wb_waddr, 7); chk("pri_first_data", wb_wdata, 64'hdead); end_cycle();
        begin_cycle(); settle(); chk("pri_second", wb_waddr, 3); chk("pri_second_we", wb_we, 1); end_cycle();

        // FIFO full: the LSU is held off while the ALU drains
        begin_cycle(); alu_valid = 1; alu_rd = 1; alu_data = 64'h11; lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99; settle(); end_cycle();
        begin_cycle(); alu_valid = 1; alu_rd = 2; alu_data = 64'h22; lsu_valid = 1; lsu_rd = 11; lsu_data = 64'hbb; settle();
        chk("full_lsu_ready0", lsu_ready, 1); end_cycle();
        begin_cycle(); alu_valid = 1; alu_rd = 6; alu_data = 64'h66; lsu_valid = 1; lsu_rd = 12; lsu_data = 64'hcc; settle();
        chk("full_alu_ready", alu_ready, 0); chk("full_lsu_ready", lsu_ready, 0); chk("full_waddr", wb_waddr, 11);
        end_cycle();
        begin_cycle(); lsu_valid = 1; lsu_rd = 12; lsu_data = 64'hcc; settle();
        chk("drain_lsu_ready", lsu_ready, 1); chk("drain_waddr", wb_waddr, 1); end_cycle();
        begin_cycle(); settle(); chk("drain_lsu_out", wb_waddr, 12); chk("drain_lsu_data", wb_wdata, 64'hcc); end_cycle();
        begin_cycle(); settle(); chk("drain_last", wb_waddr, 2); end_cycle();

        // Scoreboard: a long-latency write to rd=10, re-issued in its accept cycle
        begin_cycle(); iss_valid = 1; iss_long = 1; iss_rd = 10; chk_rs2 = 10; settle();
        chk("sb_pre", rs2_busy, 0); end_cycle();
        repeat (3) begin begin_cycle(); chk_rs2 = 10; settle(); chk("sb_wait", rs2_busy, 1); end_cycle(); end
        begin_cycle(); lsu_valid = 1; lsu_rd = 10; lsu_data = 64'ha0; iss_valid = 1; iss_long = 1; iss_rd = 10; chk_rs2 = 10; settle();
        chk("sb_accept", rs2_busy, 1); end_cycle();
        begin_cycle(); chk_rs2 = 10; settle(); chk("sb_reissued", rs2_busy, 1); end_cycle();
        begin_cycle(); lsu_valid = 1; lsu_rd = 10; lsu_data = 64'ha1; chk_rs2 = 10; settle(); end_cycle();
        begin_cycle(); chk_rs2 = 10; settle();
        chk("sb_outreg", rs2_busy, BYP ? 0 : 1); chk("sb_fwd", fwd2_valid, BYP); end_cycle();
        begin_cycle(); chk_rs2 = 10; settle(); chk("sb_done", rs2_busy, 0); end_cycle();

        // x0 results are consumed without a write
        begin_cycle(); alu_valid = 1; alu_rd = 0; alu_data = 64'h55; lsu_valid = 1; lsu_rd = 0; lsu_data = 64'h66; settle(); end_cycle();
        begin_cycle(); settle(); chk("x0_lsu_we", wb_we, 0); chk("x0_busy", rs1_busy, 0); chk("x0_fwd", fwd1_valid, 0); end_cycle();
        begin_cycle(); settle(); chk("x0_alu_we", wb_we, 0); end_cycle();

        // Reset in the middle of operation
        begin_cycle(); alu_valid = 1; alu_rd = 8; alu_data = 64'h81; lsu_valid = 1; iss_valid = 1; iss_long = 1; iss_rd = 4; settle(); end_cycle();
        begin_cycle(); alu_valid = 1; alu_rd = 9; alu_data = 64'h91; lsu_valid = 1; settle(); end_cycle();
        begin_cycle(); rst = 1; chk_rs1 = 4; chk_rs2 = 8; settle();
        chk("mid_busy4", rs1_busy, 1); chk("mid_busy8", rs2_busy, 1); end_cycle();
        begin_cycle(); settle();
        chk("post_rst_we", wb_we, 0); chk("post_rst_ready", alu_ready, 1);
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i); chk_rs2 = 5'(31 - i); #0.1;
            chk("post_rst_busy1", rs1_busy, 0); chk("post_rst_busy2", rs2_busy, 0);
        end
        end_cycle();

        // Randomized traffic
        repeat (400) begin
            begin_cycle();
            rst       = ($urandom_range(0, 59) == 0);
            alu_valid = $urandom_range(0, 9) < 6;
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = {$urandom, $urandom};
            lsu_valid = $urandom_range(0, 9) < 4;
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = {$urandom, $urandom};
            iss_valid = $urandom_range(0, 9) < 3;
            iss_long  = $urandom_range(0, 1) == 1;
            iss_rd    = 5'($urandom_range(0, 7));
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            settle();
            end_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
